// File: rtl/synth_pkg.sv
// synth_pkg: shared constants, enums and phase-increment helper for voice_synth
package synth_pkg;
  localparam int NUM_VOICES = 8;
  localparam int FRAC_BITS = 20;
  typedef enum logic [1:0] {SAW, SQUARE, TRI} wave_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [31:0] phase_inc_k(input int unsigned rate);
    logic [63:0] r;
    r = ((64'd1 << 32) + 64'(rate >> 1)) / 64'(rate);
    return r[31:0];
  endfunction
endpackage

// File: rtl/voice_wave_gen.sv
// voice_wave_gen: maps a 32-bit phase to a signed 16-bit saw, square or triangle sample
module voice_wave_gen
  import synth_pkg::*;
(
  input  logic [31:0]        phase,
  input  logic [1:0]         wave_sel,
  output logic signed [15:0] wave
);
  logic [14:0] u;
  always_comb begin
    u = phase[31] ? ~phase[30:16] : phase[30:16];
    wave = wave_t'(wave_sel) == SQUARE ? (phase[31] ? -16'sd32767 : 16'sd32767) :
           wave_t'(wave_sel) == TRI ? $signed({~u[14], u[13:0], 1'b0}) :
           $signed({~phase[31], phase[30:16]});
  end
endmodule

// File: rtl/voice_synth.sv
// voice_synth: eight-voice time-multiplexed oscillator and mixer producing 16-bit mono PCM
module voice_synth
  import synth_pkg::*;
#(
  parameter int          SAMPLE_RATE = 48000,
  parameter logic [15:0] RAMP_STEP   = 16'd64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [1:0]         wave_sel,
  input  logic [31:0]        frequencies   [NUM_VOICES-1:0],
  input  logic [31:0]        voice_volumes [NUM_VOICES-1:0],
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);
  localparam logic [31:0] K = phase_inc_k(SAMPLE_RATE);
  state_t state;
  logic [2:0] idx;
  logic signed [18:0] acc;
  logic [31:0] phase [NUM_VOICES];
  logic [15:0] gain [NUM_VOICES];
  logic [31:0] freq, vol, p, inc;
  logic [63:0] prod;
  logic [15:0] g, target, next_gain;
  logic [16:0] up;
  logic signed [15:0] wave;
  logic signed [32:0] mix;
  voice_wave_gen u_wave (.phase(p), .wave_sel(wave_sel), .wave(wave));
  assign busy = state != IDLE;
  always_comb begin
    freq = frequencies[idx];
    vol = voice_volumes[idx];
    p = phase[idx];
    g = gain[idx];
    prod = 64'(freq) * 64'(K);
    inc = prod[FRAC_BITS+31:FRAC_BITS];
    target = vol[31] ? 16'h0000 : vol >= (32'd1 << FRAC_BITS) ? 16'hFFFF : vol[19:4];
    up = {1'b0, g} + {1'b0, RAMP_STEP};
    // Ramp math is done with widened/difference compares so it never wraps at 16 bits
    next_gain = g < target ? (up > {1'b0, target} ? target : up[15:0]) :
                g > target ? (g - target <= RAMP_STEP ? target : g - RAMP_STEP) : g;
    mix = wave * $signed({1'b0, g});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      sample_out <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        gain[i] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      if (sample_en && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_en) begin
          state <= RUN;
          idx <= '0;
          acc <= '0;
        end
        RUN: begin
          phase[idx] <= p + inc;
          gain[idx] <= next_gain;
          acc <= acc + 19'($signed(mix[32:16]));
          idx <= idx + 3'd1;
          if (idx == 3'(NUM_VOICES - 1)) state <= DONE;
        end
        DONE: begin
          sample_out <= acc[18:3];
          sample_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_synth.sv
// tb_voice_synth: randomized and directed checks of voice_synth against an arithmetic reference model
module tb_voice_synth;
  logic clk = 1'b0;
  logic reset, sample_en;
  logic [1:0] wave_sel;
  logic [31:0] frequencies [7:0];
  logic [31:0] voice_volumes [7:0];
  logic signed [15:0] sample_out;
  logic sample_valid, busy, overrun;
  int total = 0, bad = 0;
  longint mph [8];
  longint mg [8];
  localparam longint P31 = 64'sd2147483648;
  localparam longint M32 = 64'sd4294967296;
  localparam longint ONE = 64'sd1048576;

  always #5 clk = ~clk;

  voice_synth dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .wave_sel(wave_sel),
    .frequencies(frequencies), .voice_volumes(voice_volumes),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mph[i] = 0;
      mg[i] = 0;
    end
  endfunction

  function automatic int model_step();
    longint acc, p, w, t, v, h;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      p = mph[i];
      v = longint'(voice_volumes[i]);
      if (wave_sel == 2'd1) w = p < P31 ? 32767 : -32767;
      else if (wave_sel == 2'd2) begin
        h = (p / 65536) % 32768;
        w = 2 * (p >= P31 ? 32767 - h : h) - 32768;
      end else w = p / 65536 - 32768;
      acc += (w * mg[i]) >>> 16;
      t = v >= P31 ? 0 : v >= ONE ? 65535 : (v / 16) % 65536;
      if (mg[i] < t) mg[i] = (mg[i] + 64 > t) ? t : mg[i] + 64;
      else if (mg[i] > t) mg[i] = (mg[i] - 64 < t) ? t : mg[i] - 64;
      mph[i] = (p + (longint'(frequencies[i]) * 89478) / ONE) % M32;
    end
    return int'(acc >>> 3);
  endfunction

  function automatic logic [31:0] rand_vol();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'h0010_0000;
      2: return $urandom | 32'h8000_0000;
      3: return $urandom_range(0, 32'h000F_FFFF);
      default: return $urandom_range(32'h0010_0000, 32'h7FFF_FFFF);
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    sample_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic sample(input string tag);
    int n, exp;
    exp = model_step();
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    n = 0;
    while (!sample_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 9);
    check({tag, " sample"}, sample_out, exp);
    check({tag, " busy"}, busy, 0);
    @(negedge clk);
    check({tag, " valid_pulse"}, sample_valid, 0);
  endtask

  task automatic count_valid(input int cycles, output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        if (first < 0) first = c + 1;
        cnt++;
      end
    end
  endtask

  initial begin
    int exp, cnt, first;
    reset = 1'b1;
    sample_en = 1'b0;
    wave_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      frequencies[i] = '0;
      voice_volumes[i] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst sample_out", sample_out, 0);
    check("rst valid", sample_valid, 0);
    check("rst busy", busy, 0);
    check("rst overrun", overrun, 0);

    for (int i = 0; i < 8; i++) frequencies[i] = $urandom;
    for (int s = 0; s < 20; s++) sample("silent");
    check("silent overrun", overrun, 0);

    for (int i = 0; i < 8; i++) frequencies[i] = '0;
    frequencies[0] = 32'd440 << 20;
    voice_volumes[0] = 32'h0010_0000;
    for (int s = 0; s < 6; s++) sample("a440");

    for (int s = 0; s < 200; s++) begin
      if (s % 10 == 0) begin
        wave_sel = 2'($urandom_range(0, 3));
        for (int i = 0; i < 8; i++) begin
          frequencies[i] = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
          voice_volumes[i] = rand_vol();
        end
      end
      sample("random");
    end

    do_reset();
    wave_sel = 2'd1;
    for (int i = 0; i < 8; i++) begin
      frequencies[i] = '0;
      voice_volumes[i] = '0;
    end
    voice_volumes[0] = 32'h0010_0000;
    for (int s = 0; s < 1025; s++) sample("sq1");
    check("sq1 full", sample_out, 4095);
    for (int i = 0; i < 8; i++) voice_volumes[i] = 32'h0010_0000;
    for (int s = 0; s < 1025; s++) sample("sq8");
    check("sq8 full", sample_out, 32766);
    for (int i = 0; i < 8; i++) voice_volumes[i] = 32'd0;
    for (int s = 0; s < 20; s++) sample("ramp_down");

    do_reset();
    wave_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      frequencies[i] = $urandom;
      voice_volumes[i] = 32'h0010_0000;
    end
    check("ovr clear", overrun, 0);
    exp = model_step();
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (4) @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    count_valid(25, cnt, first);
    check("ovr first_valid", first, 4);
    check("ovr valid_count", cnt, 1);
    check("ovr sample", sample_out, exp);
    check("ovr set", overrun, 1);
    sample("ovr after");
    check("ovr sticky", overrun, 1);

    do_reset();
    exp = model_step();
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (8) @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    check("done_edge valid", sample_valid, 1);
    check("done_edge sample", sample_out, exp);
    check("done_edge overrun", overrun, 1);
    count_valid(15, cnt, first);
    check("done_edge no_extra", cnt, 0);
    sample("done_edge after");

    do_reset();
    wave_sel = 2'd2;
    for (int s = 0; s < 5; s++) sample("pre_abort");
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("abort valid", sample_valid, 0);
    check("abort sample_out", sample_out, 0);
    check("abort busy", busy, 0);
    check("abort overrun", overrun, 0);
    count_valid(15, cnt, first);
    check("abort no_valid", cnt, 0);
    sample("post_abort");
    sample("post_abort2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/voice_synth.md
# voice_synth

Eight-voice time-multiplexed oscillator and mixer that sits directly downstream of the keyboard voice allocator. Consumes the allocator's per-voice frequency (Q12.20 Hz) and volume (Q.20 gain) arrays, runs one phase accumulator and one click-free gain ramp per voice, and on every sample strobe produces one signed 16-bit mono PCM sample for the audio output path.

## Interface
- SAMPLE_RATE, 48000: output sample rate in Hz; sets the phase-increment constant K = round(2^32 / SAMPLE_RATE), which is 89478 at 48000.
- RAMP_STEP, 64: per-sample gain change toward the target, unsigned 16-bit.
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high.
- sample_en  in  1: one-cycle sample-rate strobe.
- wave_sel  in  2: 0 = saw, 1 = square, 2 = triangle, 3 = saw.
- frequencies[7:0]  in  8x32: per-voice frequency, unsigned Q12.20 Hz.
- voice_volumes[7:0]  in  8x32: per-voice volume, Q.20; 1<<20 = full.
- sample_out  out  16: signed mixed sample; holds its value between updates.
- sample_valid  out  1: one-cycle pulse when sample_out updates.
- busy  out  1: high whenever the FSM is not in IDLE.
- overrun  out  1: sticky; set when sample_en arrives while busy; cleared only by reset.

## Operation
- Per-voice state: phase[i] (32-bit unsigned), gain[i] (16-bit unsigned). Mix accumulator acc is 19-bit signed.
- FSM IDLE:
  - sample_en -> RUN, idx = 0, acc = 0.
- FSM RUN, one voice per cycle, voice idx:
  - inc = (frequencies[idx] * K) >> 20, computed at full 49-bit width, then truncated to 32 bits.
  - phase[idx] += inc, wrapping mod 2^32. A frequency of 0 holds the phase.
  - Target gain:
    - 0 if voice_volumes[idx] bit31 = 1;
    - 16'hFFFF if voice_volumes[idx] >= 1<<20;
    - otherwise voice_volumes[idx][19:4].
  - Gain ramp:
    - gain < target: gain = min(gain + RAMP_STEP, target).
    - gain > target: gain = max(gain - RAMP_STEP, target).
    - Compute without 16-bit overflow.
  - wave is derived from the pre-update phase p = phase[idx] and the pre-update gain.
    - Saw: p[31:16] - 32768.
    - Square: +32767 if p[31] = 0, else -32767.
    - Triangle: u = p[31] ? ~p[30:16] : p[30:16] (15-bit), wave = {u, 1'b0} - 32768.
  - acc += (wave * signed{1'b0, gain}) >>> 16.
  - At idx = 7 -> DONE; otherwise idx + 1.
- FSM DONE:
  - sample_out = acc >>> 3 (no saturation needed), sample_valid = 1, -> IDLE.
- sample_en in RUN or DONE is ignored for mixing and sets overrun.
- Inputs are read live in each voice's RUN cycle; no snapshot is taken.

## Timing
- Reset values: all phase and gain = 0, state IDLE, acc = 0, sample_out = 0, sample_valid = 0, busy = 0, overrun = 0.
- sample_en sampled high at edge t: RUN covers edges t+1..t+8 (voices 0..7), DONE at edge t+9, sample_valid high for exactly the cycle after edge t+9.
- Throughput: one sample per 10 clocks. sample_en spacing < 10 cycles sets overrun.
- sample_en coincident with the DONE edge: not accepted; overrun = 1.
- Reset asserted mid-RUN: next edge returns all state to reset values. No sample_valid for the aborted sample.
- Phase wrap is silent modular arithmetic.

## Structure
- Package synth_pkg holds:
  - NUM_VOICES = 8, FRAC_BITS = 20;
  - the wave_t enum (SAW, SQUARE, TRI);
  - the state_t enum (IDLE, RUN, DONE);
  - the function for phase_inc_k(SAMPLE_RATE).
- One combinational sub-module, voice_wave_gen: phase[31:0] + wave_sel -> signed 16-bit wave.
- Phase and gain arrays live in voice_synth as register arrays indexed by idx.

## Test plan
- Reset, then 20 sample_en strobes, all volumes 0 -> every sample_out = 0, phases advance, overrun = 0.
- Voice 0 at 440<<20, others 0 -> phase[0] increments by exactly 39370320 (440 x 89478) per sample.
- voice_volumes[0] = 1<<20 from reset -> gain[0] = 64, 128, ... reaching 65535 on sample 1024. Then volume set to 0 -> gain falls by 64 per sample to 0.
- Square wave, gain[0] = 65535, phase[0] < 2^31, others silent -> sample_out = 4095 (acc = 32766). With all 8 voices in the same state -> sample_out = 32766.
- sample_en 5 cycles after the previous one -> overrun = 1 and stays set. The sample_valid for the first strobe arrives on time; no extra sample_valid is generated.
- Reset pulsed at RUN idx = 3 -> no sample_valid, sample_out = 0, busy = 0 on the next cycle.
